shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 12 +
 rtl/Add4bits.sv | 19 +
 rtl/shift_add_mult.sv | 80 ++++++++
 tb/tb_shift_add_mult.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants and state type for the shift-and-add multiplier.
package mult_pkg;
  localparam int WIDTH = 16;
  localparam int ITERS = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Add4bits.sv
// 16-bit ripple-carry adder built from explicit full-adder cells.
module Add4bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        cout,
  output logic [15:0] sum
);
  logic [16:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[16];
endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one add-and-shift per cycle, fixed 16-iteration run.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mq_q;
  logic [WIDTH-1:0]   mcand_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;

  assign addend = mq_q[0] ? mcand_q : '0;

  Add4bits u_adder (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .cout (cout),
    .sum  (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mcand_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= a;
            acc_q   <= '0;
            mq_q    <= b;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          // The 17-bit {cout,sum} shifts right: cout lands in acc_q MSB, sum LSB enters mq_q.
          acc_q <= {cout, sum[WIDTH-1:1]};
          mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {acc_q, mq_q};
  assign dbg_state = state_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks of shift_add_mult: latency, results, backpressure, reset abort.
module tb_shift_add_mult;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] product;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int lat;
  int sent;
  int recv;
  int cyc;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [31:0] exp_v;
  logic [31:0] exp_q[$];

  shift_add_mult #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Accepts one pair with out_ready=1, checks latency, result, and return to IDLE.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd17);
    check({tag, "_product"}, product, exp);
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    // Reset with in_valid asserted: must be ignored.
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_product", product, 32'h0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;

    run_op("mul_3x5", 16'd3, 16'd5, 32'h0000000F);
    run_op("mul_max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op("mul_8000x2", 16'h8000, 16'h0002, 32'h00010000);
    run_op("mul_zero", 16'h0000, 16'h1234, 32'h00000000);

    // Backpressure: hold out_ready low in DONE for 10 cycles with in_valid pulses.
    @(negedge clk);
    a = 16'h00FF;
    b = 16'h0101;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd17);
    check("bp_product", product, 32'h0000FFFF);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      check("bp_hold_product", product, 32'h0000FFFF);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a run abandons the operation.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h5678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_running", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'd5;
    b = 16'd5;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_product", product, 32'h0);
    run_op("mul_7x9", 16'd7, 16'd9, 32'h0000003F);

    // Random back-to-back traffic with random out_ready.
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 1000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check("rand_product", product, exp_v);
        recv++;
      end
      if (in_ready && sent < 1000) begin
        case ($urandom_range(0, 7))
          0: ra = 16'hFFFF;
          1: ra = 16'h0000;
          default: ra = 16'($urandom_range(0, 65535));
        endcase
        rb = 16'($urandom_range(0, 65535));
        a = ra;
        b = rb;
        in_valid = 1'b1;
        exp_q.push_back(32'(ra) * 32'(rb));
        sent++;
      end else begin
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    check("rand_received", 32'(recv), 32'd1000);
    check("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
